// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared constants, TX state type and frame-length helper for serial_link_sched
package serial_link_pkg;

  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  // Bits on the line per frame: ID, data word, and the optional trailing parity bit.
  function automatic int frame_len(input int idw, input int dw, input bit parity);
    return idw + dw + (parity ? 1 : 0);
  endfunction

endpackage

// File: rtl/serial_link_sched_if.sv
// rtl/serial_link_sched_if.sv - requester-side bus (req/data/gnt/busy) of serial_link_sched
interface serial_link_sched_if
  import serial_link_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEFAULT
);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    gnt;
  logic               busy;

  modport master (
    output req,
    output data,
    input  gnt,
    input  busy
  );

  modport slave (
    input  req,
    input  data,
    output gnt,
    output busy
  );

endinterface

// File: rtl/serial_link_sched_rr_arbiter.sv
// rtl/serial_link_sched_rr_arbiter.sv - combinational round-robin pick starting after the last winner
module rr_arbiter #(
  parameter int    NREQ = 4,
  localparam int   IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  logic [IDW-1:0] idx;

  // Walk from the farthest slot back to ptr+1 so the nearest pending requester is written last and wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_link_sched.sv
// rtl/serial_link_sched.sv - round-robin framed serial TX plus RX deframer; SERIAL_LINK_PARITY_EN adds an even-parity bit
module serial_link_sched
  import serial_link_pkg::*;
#(
  parameter int  NREQ = 4,
  parameter int  DW   = DW_DEFAULT,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_link_sched_if.slave  bus,
  output logic                ser_dout,
  output logic                ser_frame,
  input  logic                ser_din,
  input  logic                ser_frame_in,
  output logic [DW-1:0]       rx_data,
  output logic [IDW-1:0]      rx_id,
  output logic                rx_valid,
  output logic                rx_err
);

`ifdef SERIAL_LINK_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int FL  = frame_len(IDW, DW, PARITY_EN);
  localparam int CW  = $clog2(FL);
  localparam int RCW = $clog2(FL + 2);

  // ---------------------------------------------------------------- TX side
  tx_state_t       state, state_nxt;
  logic [FL-1:0]   sreg, sreg_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IDW-1:0]  win;
  logic            win_any;
  logic [DW-1:0]   win_data;
  logic [FL-1:0]   frame_word;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (win),
    .any    (win_any)
  );

  assign win_data = bus.data[int'(win)*DW +: DW];

  // ID sits in the low bits so it leaves the shift register first.
`ifdef SERIAL_LINK_PARITY_EN
  assign frame_word = {^{win_data, win}, win_data, win};
`else
  assign frame_word = {win_data, win};
`endif

  // Next-state and line outputs; req is only looked at while IDLE.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gnt_nxt   = '0;
    ser_frame = (state == SHIFT);
    ser_dout  = (state == SHIFT) & sreg[0];
    bus.busy  = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (win_any) begin
          state_nxt = SHIFT;
          sreg_nxt  = frame_word;
          cnt_nxt   = '0;
          ptr_nxt   = win;
          gnt_nxt   = NREQ'(1) << win;
        end
      end
      SHIFT: begin
        sreg_nxt = {1'b0, sreg[FL-1:1]};
        cnt_nxt  = cnt + 1'b1;
        if (cnt == CW'(FL - 1)) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // TX state register; reset parks ptr on the last slot so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      ptr     <= IDW'(NREQ - 1);
      bus.gnt <= '0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      bus.gnt <= gnt_nxt;
    end
  end

  // ---------------------------------------------------------------- RX side
  logic [FL-1:0]  rsreg;
  logic [RCW-1:0] rcnt;
  logic           frame_d;
  logic           good_q;
  logic           bad_q;
  logic           len_ok;
  logic           par_ok;

  assign len_ok = (rcnt == RCW'(FL));

  // With parity the whole received frame, parity bit included, must XOR to zero.
`ifdef SERIAL_LINK_PARITY_EN
  assign par_ok = ~^rsreg;
`else
  assign par_ok = 1'b1;
`endif

  // Deframer: shift while the strobe is high, judge the frame on its falling edge, report one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsreg    <= '0;
      rcnt     <= '0;
      frame_d  <= 1'b0;
      good_q   <= 1'b0;
      bad_q    <= 1'b0;
      rx_data  <= '0;
      rx_id    <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      frame_d  <= ser_frame_in;
      rx_valid <= good_q;
      rx_err   <= bad_q;
      good_q   <= 1'b0;
      bad_q    <= 1'b0;
      if (ser_frame_in) begin
        rsreg <= {ser_din, rsreg[FL-1:1]};
        if (rcnt != RCW'(FL + 1)) begin
          rcnt <= rcnt + 1'b1;
        end
      end else if (frame_d) begin
        rcnt <= '0;
        if (len_ok && par_ok) begin
          rx_data <= rsreg[IDW +: DW];
          rx_id   <= rsreg[IDW-1:0];
          good_q  <= 1'b1;
        end else begin
          bad_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_link_sched.sv
// tb/tb_serial_link_sched.sv - directed self-checking bench for serial_link_sched with loopback
module tb_serial_link_sched;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int IDW  = 2;
`ifdef SERIAL_LINK_PARITY_EN
  localparam int FL = 19;
`else
  localparam int FL = 18;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ser_dout;
  logic           ser_frame;
  logic           ser_din;
  logic           ser_frame_in;
  logic [DW-1:0]  rx_data;
  logic [IDW-1:0] rx_id;
  logic           rx_valid;
  logic           rx_err;
  logic           lb;
  logic           din_tb;
  logic           frame_tb;
  logic           flip;
  int             n_asrt = 0;
  int             n_fail = 0;

  logic [15:0] words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  serial_link_sched_if #(.NREQ(NREQ), .DW(DW)) bus_if ();

  serial_link_sched #(.NREQ(NREQ), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .ser_dout     (ser_dout),
    .ser_frame    (ser_frame),
    .ser_din      (ser_din),
    .ser_frame_in (ser_frame_in),
    .rx_data      (rx_data),
    .rx_id        (rx_id),
    .rx_valid     (rx_valid),
    .rx_err       (rx_err)
  );

  assign ser_din      = lb ? (ser_dout ^ flip) : din_tb;
  assign ser_frame_in = lb ? ser_frame : frame_tb;

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    tick();
    while (bus_if.gnt === '0 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_gnt_seen"}, 32'(bus_if.gnt !== '0), 1);
  endtask

  initial begin
    int nf;
    int ng;
    int ne;
    int nv;
    int n;
    logic [FL-1:0] bits;

    rst_n       = 1'b0;
    lb          = 1'b1;
    din_tb      = 1'b0;
    frame_tb    = 1'b0;
    flip        = 1'b0;
    bus_if.req  = '0;
    bus_if.data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    tick();
    tick();

    // reset values
    chk("rst_gnt", bus_if.gnt, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_dout", ser_dout, 0);
    chk("rst_frame", ser_frame, 0);
    chk("rst_rxd", rx_data, 0);
    chk("rst_rxid", rx_id, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rxerr", rx_err, 0);
    rst_n = 1'b1;
    tick();

    // single requester 2, word A5C3, looped back
    bus_if.data[32 +: 16] = 16'hA5C3;
    bus_if.req = 4'b0100;
    wait_gnt("t1");
    chk("t1_gnt", bus_if.gnt, 4'b0100);
    chk("t1_busy", bus_if.busy, 1);
    chk("t1_frame", ser_frame, 1);
    bus_if.req = '0;
    bits = '0;
    bits[0] = ser_dout;
    nf = 1;
    ng = 0;
    for (int i = 1; i < FL; i++) begin
      tick();
      bits[i] = ser_dout;
      nf += int'(ser_frame);
      ng += int'(bus_if.gnt != '0);
    end
`ifdef SERIAL_LINK_PARITY_EN
    chk("t1_bits", bits, 19'h6970E);
`else
    chk("t1_bits", bits, 18'h2970E);
`endif
    chk("t1_nframe", nf, FL);
    chk("t1_gnt_once", ng, 0);
    tick();
    chk("t1_gap_frame", ser_frame, 0);
    chk("t1_gap_busy", bus_if.busy, 1);
    chk("t1_gap_rxv", rx_valid, 0);
    tick();
    chk("t1_idle_busy", bus_if.busy, 0);
    chk("t1_early_rxv", rx_valid, 0);
    tick();
    chk("t1_rxv", rx_valid, 1);
    chk("t1_rxd", rx_data, 16'hA5C3);
    chk("t1_rxid", rx_id, 2);
    tick();
    chk("t1_rxv_pulse", rx_valid, 0);
    bus_if.data[32 +: 16] = 16'h3333;

    // all four held after a fresh reset: grants 0,1,2,3,0 every FL+2 cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_if.req = 4'hF;
    wait_gnt("t2");
    chk("t2_gnt0", bus_if.gnt, 4'b0001);
    for (int i = 1; i <= 4; i++) begin
      repeat (FL + 2) tick();
      chk("t2_gnt", bus_if.gnt, 32'(1) << (i % 4));
      chk("t2_rxv", rx_valid, 1);
      chk("t2_rxid", rx_id, (i - 1) % 4);
      chk("t2_rxd", rx_data, words[(i - 1) % 4]);
      if (i == 4) bus_if.req = '0;
    end
    repeat (FL + 2) tick();
    chk("t2_last_rxv", rx_valid, 1);
    chk("t2_last_rxid", rx_id, 0);
    chk("t2_last_rxd", rx_data, 16'h1111);

    // req[1] arrives mid-frame of requester 3
    bus_if.req = 4'b1000;
    wait_gnt("t3");
    chk("t3_gnt3", bus_if.gnt, 4'b1000);
    bus_if.req = '0;
    repeat (5) tick();
    bus_if.req = 4'b0010;
    ng = 0;
    for (int i = 6; i < FL + 2; i++) begin
      tick();
      ng += int'(bus_if.gnt != '0);
    end
    chk("t3_no_early_gnt", ng, 0);
    chk("t3_idle_busy", bus_if.busy, 0);
    tick();
    chk("t3_gnt1", bus_if.gnt, 4'b0010);
    chk("t3_rxid3", rx_id, 3);
    chk("t3_rxd3", rx_data, 16'h4444);
    bus_if.req = '0;
    repeat (FL + 2) tick();
    chk("t3_rxv1", rx_valid, 1);
    chk("t3_rxid1", rx_id, 1);
    chk("t3_rxd1", rx_data, 16'h2222);

    // truncated 10-bit frame driven straight onto the receiver
    lb = 1'b0;
    frame_tb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din_tb = 1'($urandom_range(0, 1));
      tick();
    end
    frame_tb = 1'b0;
    tick();
    chk("t4_err_early", rx_err, 0);
    tick();
    chk("t4_err", rx_err, 1);
    chk("t4_rxv", rx_valid, 0);
    chk("t4_rxd_hold", rx_data, 16'h2222);
    chk("t4_rxid_hold", rx_id, 1);
    tick();
    chk("t4_err_pulse", rx_err, 0);
    lb = 1'b1;

    // reset while bit 7 is on the line
    bus_if.req = 4'b0100;
    wait_gnt("t5");
    chk("t5_gnt2", bus_if.gnt, 4'b0100);
    bus_if.req = '0;
    repeat (7) tick();
    chk("t5_bit7_frame", ser_frame, 1);
    rst_n = 1'b0;
    tick();
    chk("t5_frame", ser_frame, 0);
    chk("t5_busy", bus_if.busy, 0);
    chk("t5_gnt", bus_if.gnt, 0);
    chk("t5_dout", ser_dout, 0);
    chk("t5_rxd", rx_data, 0);
    chk("t5_rxid", rx_id, 0);
    chk("t5_rxv", rx_valid, 0);
    chk("t5_rxerr", rx_err, 0);
    rst_n = 1'b1;
    bus_if.req = 4'b1101;
    wait_gnt("t5b");
    chk("t5_first_gnt", bus_if.gnt, 4'b0001);
    bus_if.req = '0;
    ne = 0;
    for (int i = 0; i < FL + 2; i++) begin
      tick();
      ne += int'(rx_err);
    end
    chk("t5_no_err", ne, 0);
    chk("t5_rxv", rx_valid, 1);
    chk("t5_rxid0", rx_id, 0);
    chk("t5_rxd0", rx_data, 16'h1111);

`ifdef SERIAL_LINK_PARITY_EN
    // one flipped bit must be rejected, then a clean 19-bit frame accepted
    bus_if.req = 4'b0010;
    wait_gnt("t6");
    bus_if.req = '0;
    repeat (5) tick();
    flip = 1'b1;
    tick();
    flip = 1'b0;
    ne = 0;
    nv = 0;
    for (int i = 0; i < FL + 4; i++) begin
      tick();
      ne += int'(rx_err);
      nv += int'(rx_valid);
    end
    chk("t6_par_err", ne, 1);
    chk("t6_par_nv", nv, 0);
    chk("t6_rxd_hold", rx_data, 16'h1111);
    chk("t6_rxid_hold", rx_id, 0);
    bus_if.req = 4'b0010;
    wait_gnt("t6b");
    bus_if.req = '0;
    nf = 1;
    n = 0;
    while (ser_frame && n < 40) begin
      tick();
      if (ser_frame) nf++;
      n++;
    end
    chk("t6_fl19", nf, 19);
    tick();
    tick();
    chk("t6_rxv", rx_valid, 1);
    chk("t6_rxd", rx_data, 16'h2222);
    chk("t6_rxid", rx_id, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
